// File: rtl/bandai_mapper_v2.sv
// Bandai-style cartridge mapper: an address-sequence unlock, then a serial bit-stream,
// then an open state where bank registers drive the banked ROM/RAM address.
module bandai_mapper_v2 #(
  parameter int          NBANK       = 4,
  parameter int          BANK_W      = 8,
  parameter int          RADDR_W     = 7,
  parameter int          SEQ_LEN     = 2,
  parameter logic [31:0] UNLOCK_SEQ  = 32'h0000A55A,
  parameter int          BS_LEN      = 18,
  parameter logic [31:0] BS_VALUE    = 32'h00005140,
  parameter int          TIMEOUT     = 255,
  parameter logic [7:0]  BR_BASE     = 8'hC0,
  parameter logic [7:0]  RELOCK_ADDR = 8'hCF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               CEn,
  input  logic               WEn,
  input  logic               OEn,
  input  logic               SSn,
  input  logic [7:0]         ADDR,
  input  logic [7:0]         DQ_IN,
  output logic [7:0]         DQ_OUT,
  output logic               DQ_OE,
  output logic               SO,
  output logic               SO_OE,
  output logic               ROMCEn,
  output logic               RAMCEn,
  output logic [RADDR_W-1:0] RADDR
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(BS_LEN);
  localparam logic [TW-1:0]     TO_V     = TW'(TIMEOUT);
  localparam logic [SW-1:0]     BS_LAST  = SW'(BS_LEN - 1);
  localparam logic [1:0]        SEQ_LAST = 2'(SEQ_LEN - 1);
  localparam logic [BS_LEN-1:0] BS_INIT  = BS_VALUE[BS_LEN-1:0];

  typedef enum logic [1:0] {
    ST_SEQ    = 2'd0,
    ST_STREAM = 2'd1,
    ST_OPEN   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        step_q, step_d;
  logic [TW-1:0]     tmo_q, tmo_d, tmo_inc;
  logic [SW-1:0]     bit_q, bit_d;
  logic [BS_LEN-1:0] sr_q, sr_d;
  logic [BANK_W-1:0] br_q [NBANK];

  logic              unlocked, host_sel, wr_cyc, rd_cyc, in_win, relock;
  logic              rce, ram_ce, rom_ce;
  logic [7:0]        win_off, unlock_step;
  logic [31:0]       useq;
  logic [3:0]        region;
  logic [BANK_W-1:0] wdata, rd_bank, reg_bank;
  logic [RADDR_W-1:0] lin_addr;

  assign useq        = UNLOCK_SEQ;
  assign unlock_step = useq[{step_q, 3'b000} +: 8];
  assign tmo_inc     = tmo_q + 1'b1;

  assign unlocked = (state_q == ST_STREAM) || (state_q == ST_OPEN);
  assign host_sel = ~(SSn & CEn);
  // Both strobes low at once is treated as a bus glitch: neither read nor write.
  assign wr_cyc   = unlocked && host_sel && OEn && !WEn;
  assign rd_cyc   = unlocked && host_sel && !OEn && WEn;
  assign win_off  = ADDR - BR_BASE;
  assign in_win   = win_off < 8'(NBANK);
  assign relock   = wr_cyc && (ADDR == RELOCK_ADDR) && (DQ_IN == 8'h00);
  assign wdata    = BANK_W'(DQ_IN);

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    tmo_d   = tmo_q;
    bit_d   = bit_q;
    sr_d    = {1'b1, sr_q[BS_LEN-1:1]};
    case (state_q)
      ST_SEQ: begin
        if (ADDR == unlock_step) begin
          tmo_d = '0;
          if (step_q == SEQ_LAST) begin
            state_d = ST_STREAM;
            step_d  = '0;
            bit_d   = '0;
            sr_d    = BS_INIT;
          end else begin
            step_d = step_q + 2'd1;
          end
        end else if (step_q != 2'd0) begin
          if (tmo_inc == TO_V) begin
            step_d = '0;
            tmo_d  = '0;
          end else begin
            tmo_d = tmo_inc;
          end
        end
      end
      ST_STREAM: begin
        if (bit_q == BS_LAST) begin
          state_d = ST_OPEN;
          bit_d   = '0;
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
      ST_OPEN: ;
      default: state_d = ST_SEQ;
    endcase
    if (relock) begin
      state_d = ST_SEQ;
      step_d  = '0;
      tmo_d   = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_SEQ;
      step_q  <= '0;
      tmo_q   <= '0;
      bit_q   <= '0;
      sr_q    <= '1;
      for (int i = 0; i < NBANK; i++) br_q[i] <= '1;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      tmo_q   <= tmo_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      for (int i = 0; i < NBANK; i++) begin
        if (wr_cyc && in_win && (win_off == 8'(i))) br_q[i] <= wdata;
      end
    end
  end

  assign region = ADDR[7:4];

  always_comb begin
    rd_bank  = '0;
    reg_bank = '0;
    for (int i = 0; i < NBANK; i++) begin
      if (win_off == 8'(i)) rd_bank = br_q[i];
      if (region == 4'(i))  reg_bank = br_q[i];
    end
  end

  assign DQ_OE  = rd_cyc && in_win;
  assign DQ_OUT = DQ_OE ? 8'(rd_bank) : 8'h00;

  assign SO     = (state_q == ST_STREAM) ? sr_q[0] : 1'b1;
  assign SO_OE  = ~RST;

  assign rce    = unlocked && SSn && !CEn;
  assign ram_ce = rce && (region == 4'd1);
  assign rom_ce = rce && (region > 4'd1);
  assign RAMCEn = ~ram_ce;
  assign ROMCEn = ~rom_ce;

  // Regions past the bank registers map linearly, with BR0 supplying the low bits.
  assign lin_addr = {region, br_q[0][RADDR_W-5:0]};
  assign RADDR    = !(ram_ce || rom_ce) ? '0 :
                    (region < 4'(NBANK)) ? reg_bank[RADDR_W-1:0] : lin_addr;

endmodule

// File: tb/tb_bandai_mapper_v2.sv
// Directed bench for bandai_mapper_v2: unlock/timeout, bit-stream, bank access,
// region mapping, relock and mid-stream reset.
module tb_bandai_mapper_v2;

  logic       CLK, RST, CEn, WEn, OEn, SSn;
  logic [7:0] ADDR, DQ_IN, DQ_OUT;
  logic       DQ_OE, SO, SO_OE, ROMCEn, RAMCEn;
  logic [6:0] RADDR;

  logic [7:0] exp_q[$];
  int         total = 0;
  int         bad   = 0;
  logic [31:0] bs_v = 32'h00005140;

  bandai_mapper_v2 dut (
    .CLK(CLK), .RST(RST), .CEn(CEn), .WEn(WEn), .OEn(OEn), .SSn(SSn),
    .ADDR(ADDR), .DQ_IN(DQ_IN), .DQ_OUT(DQ_OUT), .DQ_OE(DQ_OE),
    .SO(SO), .SO_OE(SO_OE), .ROMCEn(ROMCEn), .RAMCEn(RAMCEn), .RADDR(RADDR)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic smp();
    @(negedge CLK);
  endtask

  // scoreboard
  task automatic push(input logic [7:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [7:0] obs);
    logic [7:0] exp_v;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL %s: got %0h but expected queue is empty", tag, obs);
    end else begin
      exp_v = exp_q.pop_front();
      assert (obs === exp_v) else begin
        bad++;
        $error("FAIL %s: got %0h want %0h", tag, obs, exp_v);
      end
    end
  endtask

  // drivers
  task automatic idle();
    CEn = 1'b1; SSn = 1'b1; WEn = 1'b1; OEn = 1'b1;
  endtask

  task automatic host_wr(input logic [7:0] a, input logic [7:0] d);
    SSn = 1'b0; CEn = 1'b1; OEn = 1'b1; WEn = 1'b0; ADDR = a; DQ_IN = d;
    cyc();
    idle(); ADDR = 8'h00; DQ_IN = 8'h00;
  endtask

  task automatic host_rd(input string tag, input logic [7:0] a,
                         input logic oe, input logic [7:0] dq);
    SSn = 1'b0; CEn = 1'b1; OEn = 1'b0; WEn = 1'b1; ADDR = a;
    push({7'd0, oe}); push(dq);
    smp();
    check({tag, "_oe"}, {7'd0, DQ_OE});
    check({tag, "_dq"}, DQ_OUT);
    cyc();
    idle(); ADDR = 8'h00;
  endtask

  task automatic mem(input string tag, input logic [7:0] a, input logic rom_n,
                     input logic ram_n, input logic [6:0] ra);
    SSn = 1'b1; CEn = 1'b0; OEn = 1'b1; WEn = 1'b1; ADDR = a;
    push({7'd0, rom_n}); push({7'd0, ram_n}); push({1'b0, ra});
    smp();
    check({tag, "_romcen"}, {7'd0, ROMCEn});
    check({tag, "_ramcen"}, {7'd0, RAMCEn});
    check({tag, "_raddr"}, {1'b0, RADDR});
    cyc();
    idle(); ADDR = 8'h00;
  endtask

  task automatic unlock(input int gap);
    ADDR = 8'h5A; cyc();
    ADDR = 8'h00;
    repeat (gap) cyc();
    ADDR = 8'hA5; cyc();
    ADDR = 8'h00;
  endtask

  task automatic stream_check(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      push({7'd0, bs_v[i]});
      smp();
      check(tag, {7'd0, SO});
      cyc();
    end
  endtask

  task automatic so_idle_check(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      push(8'd1);
      smp();
      check(tag, {7'd0, SO});
      cyc();
    end
  endtask

  initial begin
    idle(); ADDR = 8'h00; DQ_IN = 8'h00; RST = 1'b1;
    cyc(); cyc();
    push(8'd0); smp(); check("so_oe_in_rst", {7'd0, SO_OE});
    cyc();
    RST = 1'b0;
    cyc();
    push(8'd1); push(8'd1); push(8'd0); push(8'd0);
    smp();
    check("rst_so", {7'd0, SO});
    check("rst_so_oe", {7'd0, SO_OE});
    check("rst_dq_oe", {7'd0, DQ_OE});
    check("rst_dq_out", DQ_OUT);
    cyc();
    mem("rst_mem", 8'h20, 1'b1, 1'b1, 7'h00);
    host_rd("locked_rd", 8'hC0, 1'b0, 8'h00);

    // one idle cycle too many: sequence abandoned, no stream
    unlock(255);
    ADDR = 8'h20; SSn = 1'b1; CEn = 1'b0;
    for (int i = 0; i < 20; i++) begin
      push(8'd1); push(8'd1);
      smp();
      check("tmo_so", {7'd0, SO});
      check("tmo_romcen", {7'd0, ROMCEn});
      cyc();
    end
    idle(); ADDR = 8'h00;

    // one idle cycle fewer still unlocks
    unlock(254);
    stream_check("stream1_so", 18);
    so_idle_check("open_so", 2);
    host_rd("open_rd_c0", 8'hC0, 1'b1, 8'hFF);

    // completed sequence in OPEN does not restart the stream
    unlock(0);
    so_idle_check("no_retrigger_so", 20);

    host_wr(8'hC2, 8'h3C);
    host_rd("rd_c2", 8'hC2, 1'b1, 8'h3C);
    mem("rom_r2", 8'h20, 1'b0, 1'b1, 7'h3C);

    host_wr(8'hC0, 8'h05);
    host_wr(8'hC1, 8'h47);
    mem("rom_r5", 8'h50, 1'b0, 1'b1, 7'h2D);
    mem("rom_r4", 8'h40, 1'b0, 1'b1, 7'h25);
    mem("rom_rf", 8'hF0, 1'b0, 1'b1, 7'h7D);
    mem("ram_r1", 8'h10, 1'b1, 1'b0, 7'h47);
    mem("rom_r3", 8'h30, 1'b0, 1'b1, 7'h7F);
    mem("r0_none", 8'h05, 1'b1, 1'b1, 7'h00);

    // both strobes low: neither read nor write
    SSn = 1'b0; CEn = 1'b1; OEn = 1'b0; WEn = 1'b0; ADDR = 8'hC2; DQ_IN = 8'hAA;
    push(8'd0); push(8'd0);
    smp();
    check("both_low_oe", {7'd0, DQ_OE});
    check("both_low_dq", DQ_OUT);
    cyc();
    idle(); ADDR = 8'h00; DQ_IN = 8'h00;
    host_rd("rd_c2_kept", 8'hC2, 1'b1, 8'h3C);

    host_wr(8'hC4, 8'h11);
    host_rd("rd_c4_outside", 8'hC4, 1'b0, 8'h00);
    host_rd("rd_c3_edge", 8'hC3, 1'b1, 8'hFF);

    // relock with nonzero data is ignored
    host_wr(8'hCF, 8'h01);
    host_rd("relock_nz_rd", 8'hC0, 1'b1, 8'h05);

    host_wr(8'hCF, 8'h00);
    host_rd("relocked_rd", 8'hC0, 1'b0, 8'h00);
    mem("relocked_mem", 8'h20, 1'b1, 1'b1, 7'h00);

    // banks survive relock; reset mid-stream overrides a concurrent write
    unlock(0);
    stream_check("stream2_so", 4);
    host_rd("stream_rd_c0", 8'hC0, 1'b1, 8'h05);
    RST = 1'b1;
    SSn = 1'b0; CEn = 1'b1; OEn = 1'b1; WEn = 1'b0; ADDR = 8'hC0; DQ_IN = 8'h12;
    push(8'd0); smp(); check("mid_rst_so_oe", {7'd0, SO_OE});
    cyc();
    RST = 1'b0; idle(); ADDR = 8'h00; DQ_IN = 8'h00;
    push(8'd1); push(8'd1); push(8'd0);
    smp();
    check("post_rst_so", {7'd0, SO});
    check("post_rst_so_oe", {7'd0, SO_OE});
    check("post_rst_dq_oe", {7'd0, DQ_OE});
    cyc();

    unlock(0);
    stream_check("stream3_so", 18);
    so_idle_check("open3_so", 1);
    host_rd("br0_ff", 8'hC0, 1'b1, 8'hFF);
    host_rd("br1_ff", 8'hC1, 1'b1, 8'hFF);
    host_rd("br2_ff", 8'hC2, 1'b1, 8'hFF);
    host_rd("br3_ff", 8'hC3, 1'b1, 8'hFF);

    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL leftover_exp: got %0d entries want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
